// File: rtl/i2c_apb_txn_sequencer.sv
// i2c_apb_txn_sequencer: round-robin APB master that runs complete I2C write transactions
// (prescaler, address, payload, enable, status poll, disable) for two requesters.
module i2c_apb_txn_sequencer #(
  parameter logic [7:0] PRESCALER = 8'd4,
  parameter int MAX_LEN = 8,
  parameter int POLL_MAX = 255
) (
  input  logic        pclk_i,
  input  logic        preset_n_i,
  input  logic [1:0]  req_valid_i,
  input  logic [15:0] req_addr_rw_i,
  input  logic [7:0]  req_len_i,
  input  logic [15:0] data_i,
  input  logic [1:0]  data_valid_i,
  output logic [1:0]  data_ready_o,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [7:0]  paddr_o,
  output logic [7:0]  pwdata_o,
  input  logic [7:0]  prdata_i,
  input  logic        pready_i
);
  localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);
  localparam logic [7:0] POLL_LIM = 8'(POLL_MAX);

  typedef enum logic [3:0] {IDLE, GRANT, WR_PRESC, WR_ADDR, FETCH, WR_TX, WR_GO, POLL, WR_OFF, DONE} state_t;
  // every APB transfer walks gap -> setup -> access, so psel drops for a cycle after each completion
  typedef enum logic [1:0] {P_GAP, P_SETUP, P_ACCESS} phase_t;

  state_t state, state_nx;
  phase_t phase, phase_nx;
  logic g, g_nx, last, last_nx, err, err_nx, win, apb_st, xfer_done;
  logic [7:0] addr_rw, addr_rw_nx, tx_byte, tx_byte_nx, polls, polls_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] oh;
  logic unused_prdata;

  assign unused_prdata = ^{prdata_i[7:6], prdata_i[4:0]};
  assign apb_st = state inside {WR_PRESC, WR_ADDR, WR_TX, WR_GO, POLL, WR_OFF};
  assign xfer_done = apb_st && phase == P_ACCESS && pready_i;
  assign win = &req_valid_i ? ~last : req_valid_i[1];

  always_ff @(posedge pclk_i or negedge preset_n_i)
    if (!preset_n_i) begin
      state <= IDLE;
      phase <= P_GAP;
      g <= 1'b0;
      last <= 1'b1;
      err <= 1'b0;
      addr_rw <= 8'h00;
      tx_byte <= 8'h00;
      polls <= 8'h00;
      cnt <= 4'h0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      g <= g_nx;
      last <= last_nx;
      err <= err_nx;
      addr_rw <= addr_rw_nx;
      tx_byte <= tx_byte_nx;
      polls <= polls_nx;
      cnt <= cnt_nx;
    end

  always_comb begin
    state_nx = state;
    g_nx = g;
    last_nx = last;
    err_nx = err;
    addr_rw_nx = addr_rw;
    tx_byte_nx = tx_byte;
    polls_nx = polls;
    cnt_nx = cnt;
    phase_nx = !apb_st ? P_GAP : phase == P_GAP ? P_SETUP : phase == P_SETUP ? P_ACCESS :
               pready_i ? P_GAP : P_ACCESS;
    case (state)
      IDLE: if (|req_valid_i) begin
        state_nx = GRANT;
        g_nx = win;
        addr_rw_nx = win ? req_addr_rw_i[15:8] : req_addr_rw_i[7:0];
        cnt_nx = win ? req_len_i[7:4] : req_len_i[3:0];
        err_nx = 1'b0;
        polls_nx = 8'h00;
      end
      GRANT: begin
        err_nx = cnt == 4'h0 || {1'b0, cnt} > LEN_MAX;
        state_nx = err_nx ? DONE : WR_PRESC;
      end
      WR_PRESC: state_nx = xfer_done ? WR_ADDR : state;
      WR_ADDR:  state_nx = xfer_done ? FETCH : state;
      FETCH: if (data_valid_i[g]) begin
        tx_byte_nx = g ? data_i[15:8] : data_i[7:0];
        state_nx = WR_TX;
      end
      WR_TX: if (xfer_done) begin
        cnt_nx = cnt - 4'd1;
        state_nx = cnt == 4'd1 ? WR_GO : FETCH;
      end
      WR_GO: state_nx = xfer_done ? POLL : state;
      POLL: if (xfer_done) begin
        polls_nx = polls + 8'd1;
        err_nx = !prdata_i[5] && polls_nx == POLL_LIM;
        state_nx = prdata_i[5] || err_nx ? WR_OFF : POLL;
      end
      WR_OFF: state_nx = xfer_done ? DONE : state;
      DONE: begin
        last_nx = g;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign oh = g ? 2'b10 : 2'b01;
  assign busy_o = state != IDLE;
  assign gnt_o = busy_o ? oh : 2'b00;
  assign done_o = state == DONE ? oh : 2'b00;
  assign err_o = state == DONE && err;
  assign data_ready_o = state == FETCH ? oh : 2'b00;
  assign psel_o = apb_st && phase != P_GAP;
  assign penable_o = apb_st && phase == P_ACCESS;
  assign pwrite_o = psel_o && state != POLL;
  assign paddr_o = !psel_o ? 8'h00 : state == WR_ADDR ? 8'h04 : state == WR_TX ? 8'h02 :
                   state == POLL ? 8'h05 : state == WR_PRESC ? 8'h00 : 8'h01;
  assign pwdata_o = !pwrite_o ? 8'h00 : state == WR_PRESC ? PRESCALER : state == WR_ADDR ? addr_rw :
                    state == WR_TX ? tx_byte : state == WR_GO ? 8'h60 : 8'h20;
endmodule

// File: tb/tb_i2c_apb_txn_sequencer.sv
// tb_i2c_apb_txn_sequencer: transaction-level model predicts each grant's APB op list, done and err;
// directed scenarios pin the model with literal expectations, then random traffic from both requesters.
module tb_i2c_apb_txn_sequencer;
  localparam int POLL_MAX = 4;
  localparam int MAX_LEN = 8;

  typedef struct packed {logic w; logic [7:0] a; logic [7:0] d;} op_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid_i = '0, data_valid_i = '0;
  logic [15:0] req_addr_rw_i = '0, data_i = '0;
  logic [7:0] req_len_i = '0, prdata_i = '0;
  logic pready_i = 1'b1;
  logic [1:0] data_ready_o, gnt_o, done_o;
  logic err_o, busy_o, psel_o, penable_o, pwrite_o;
  logic [7:0] paddr_o, pwdata_o;

  i2c_apb_txn_sequencer #(.PRESCALER(8'd4), .MAX_LEN(MAX_LEN), .POLL_MAX(POLL_MAX)) dut (
    .pclk_i(clk), .preset_n_i(rst_n), .req_valid_i(req_valid_i), .req_addr_rw_i(req_addr_rw_i),
    .req_len_i(req_len_i), .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic [7:0] d_addr [2];
  logic [3:0] d_len [2];
  int d_polls [2];
  logic [7:0] d_bytes [2][16];
  logic [3:0] bidx [2];
  int rd_cnt = 0, stall_n = 0;
  bit rdy_rand = 0, stall = 0;

  op_t expq[$], apb_log[$];
  logic [1:0] glog[$];
  bit m_busy = 0, m_g = 0, m_last = 1, m_err = 0;
  int due = 0, acc4 = 0;
  bit psel_seen = 0;
  logic [1:0] last_done = '0, p_gnt = '0;
  logic last_err = 0;
  logic p_psel = 0, p_cmp = 0, p_w = 0;
  logic [7:0] p_a = '0, p_d = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // stimulus: payload bytes, APB slave responses
  always @(posedge clk) begin
    #1;
    for (int r = 0; r < 2; r++) begin
      data_valid_i[r] = req_valid_i[r] && ($urandom_range(0, 2) != 0);
      data_i[r*8 +: 8] = d_bytes[r][bidx[r]];
    end
    if (!stall) stall_n = 0;
    if (stall && psel_o && penable_o && paddr_o == 8'h04 && stall_n < 3) begin
      pready_i = 1'b0;
      stall_n++;
    end else pready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    prdata_i = (rd_cnt + 1 >= d_polls[gnt_o[1]]) ? 8'h20 : 8'h00;
  end

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++)
      if (!rst_n || !req_valid_i[r]) bidx[r] = 4'h0;
      else if (data_valid_i[r] && data_ready_o[r]) bidx[r] = bidx[r] + 4'h1;
    if (!busy_o) rd_cnt = 0;
    else if (psel_o && penable_o && pready_i && !pwrite_o) rd_cnt++;
  end

  // reference model and compare process
  always @(negedge clk) begin
    logic cmp, w, expdone;
    logic [1:0] oh;
    int nrd;
    op_t e;
    if (!rst_n) begin
      m_busy = 0; due = 0; m_last = 1; expq.delete();
      p_psel = 0; p_cmp = 0; p_gnt = '0;
    end else begin
      cmp = psel_o && penable_o && pready_i;
      if (p_cmp) chk("apb_drop", psel_o, 0);
      else if (p_psel) chk("apb_hold", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o}, {2'b11, p_w, p_a, p_d});
      else if (psel_o) chk("apb_setup", penable_o, 0);
      if (m_busy) begin
        oh = m_g ? 2'b10 : 2'b01;
        chk("gnt", gnt_o, oh);
        chk("busy", busy_o, 1);
        chk("ready_other", data_ready_o & ~oh, 0);
        expdone = due == 1;
        chk("done", done_o, expdone ? oh : 2'b00);
        if (expdone) chk("err", err_o, m_err);
        if (due > 0) due--;
        if (cmp) begin
          if (expq.size() == 0) begin
            checks++; errs++;
            $display("FAIL apb_extra: got op %0h with none pending", {pwrite_o, paddr_o, pwdata_o});
          end else begin
            e = expq.pop_front();
            chk("apb_op", {pwrite_o, paddr_o, pwrite_o ? pwdata_o : 8'h00}, e);
            if (expq.size() == 0) due = 1;
          end
        end
        if (expdone) begin m_busy = 0; m_last = m_g; end
      end else begin
        chk("idle_outs", {gnt_o, done_o, err_o, busy_o, psel_o, data_ready_o}, 0);
        if (|req_valid_i) begin
          w = &req_valid_i ? !m_last : req_valid_i[1];
          m_g = w; m_busy = 1; m_err = 0; due = 0;
          if (d_len[w] == 0 || d_len[w] > MAX_LEN) begin
            m_err = 1; due = 2;
          end else begin
            expq.push_back({1'b1, 8'h00, 8'h04});
            expq.push_back({1'b1, 8'h04, d_addr[w]});
            for (int i = 0; i < int'(d_len[w]); i++) expq.push_back({1'b1, 8'h02, d_bytes[w][i]});
            expq.push_back({1'b1, 8'h01, 8'h60});
            nrd = d_polls[w] > POLL_MAX ? POLL_MAX : d_polls[w];
            m_err = d_polls[w] > POLL_MAX;
            for (int i = 0; i < nrd; i++) expq.push_back({1'b0, 8'h05, 8'h00});
            expq.push_back({1'b1, 8'h01, 8'h20});
          end
        end
      end
      if (cmp) apb_log.push_back({pwrite_o, paddr_o, pwrite_o ? pwdata_o : 8'h00});
      if (|done_o) begin last_done = done_o; last_err = err_o; end
      if (psel_o && penable_o && paddr_o == 8'h04) acc4++;
      if (psel_o) psel_seen = 1;
      if (|gnt_o && p_gnt == 0) glog.push_back(gnt_o);
      p_gnt = gnt_o; p_psel = psel_o; p_cmp = cmp; p_w = pwrite_o; p_a = paddr_o; p_d = pwdata_o;
    end
  end

  task automatic drive_ports(input int r);
    req_addr_rw_i[r*8 +: 8] = d_addr[r];
    req_len_i[r*4 +: 4] = d_len[r];
  endtask

  task automatic start_req(input int r, input logic [7:0] a, input int len, input int polls);
    d_addr[r] = a; d_len[r] = 4'(len); d_polls[r] = polls;
    for (int i = 0; i < 16; i++) d_bytes[r][i] = 8'($urandom);
    drive_ports(r);
    req_valid_i[r] = 1'b1;
  endtask

  task automatic wait_done(input int r, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (gnt_o[r]) begin
        req_addr_rw_i[r*8 +: 8] = 8'($urandom);
        req_len_i[r*4 +: 4] = 4'($urandom);
      end
    end while (!done_o[r] && n < 4000);
    if (!done_o[r]) begin
      checks++; errs++;
      $display("FAIL done_timeout: requester %0d got no done after %0d cycles", r, n);
    end
    @(posedge clk); #1;
    req_valid_i[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("reset_outs", {gnt_o, done_o, err_o, busy_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, data_ready_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_txns(input int r);
    int n;
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
      start_req(r, 8'($urandom), $urandom_range(0, 12), $urandom_range(1, 6));
      wait_done(r, n);
    end
  endtask

  initial begin
    int n, nrd;
    op_t lit1 [7];
    lit1 = '{{1'b1, 8'h00, 8'h04}, {1'b1, 8'h04, 8'hA0}, {1'b1, 8'h02, 8'h11}, {1'b1, 8'h02, 8'h22},
             {1'b1, 8'h01, 8'h60}, {1'b0, 8'h05, 8'h00}, {1'b1, 8'h01, 8'h20}};
    for (int r = 0; r < 2; r++) begin d_addr[r] = '0; d_len[r] = '0; d_polls[r] = 1;
      for (int i = 0; i < 16; i++) d_bytes[r][i] = '0; end
    @(posedge clk); #1;
    do_reset();

    // single write transaction, zero wait states
    apb_log.delete();
    start_req(0, 8'hA0, 2, 1);
    d_bytes[0][0] = 8'h11; d_bytes[0][1] = 8'h22;
    wait_done(0, n);
    chk("s1_nops", apb_log.size(), 7);
    for (int i = 0; i < 7; i++) if (i < apb_log.size()) chk("s1_op", apb_log[i], lit1[i]);
    chk("s1_done", last_done, 2'b01);
    chk("s1_err", last_err, 0);

    // simultaneous requests, twice
    @(posedge clk); #1;
    do_reset();
    glog.delete();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start_req(0, 8'h30, 1, 1);
      start_req(1, 8'h31, 2, 2);
      fork
        begin int m; wait_done(0, m); end
        begin int m; wait_done(1, m); end
      join
    end
    chk("s2_ngrants", glog.size(), 4);
    for (int i = 0; i < 4; i++) if (i < glog.size()) chk("s2_grant", glog[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // zero length rejected without APB traffic
    repeat (2) @(posedge clk); #1;
    psel_seen = 0;
    start_req(1, 8'h44, 0, 1);
    wait_done(1, n);
    chk("s3_cycles", n, 3);
    chk("s3_psel", psel_seen, 0);
    chk("s3_done", last_done, 2'b10);
    chk("s3_err", last_err, 1);

    // status never reports tx_empty: poll timeout
    repeat (2) @(posedge clk); #1;
    apb_log.delete();
    start_req(0, 8'h52, 1, 200);
    wait_done(0, n);
    nrd = 0;
    foreach (apb_log[i]) if (apb_log[i].a == 8'h05 && !apb_log[i].w) nrd++;
    chk("s4_reads", nrd, 4);
    if (apb_log.size() > 0) chk("s4_last", apb_log[apb_log.size() - 1], {1'b1, 8'h01, 8'h20});
    chk("s4_err", last_err, 1);

    // wait states on the address write
    repeat (2) @(posedge clk); #1;
    stall = 1; acc4 = 0;
    start_req(0, 8'hA0, 1, 1);
    wait_done(0, n);
    chk("s5_access_cycles", acc4, 4);
    stall = 0;

    // reset in the middle of a TX write, pending request re-runs from the start
    rdy_rand = 1;
    repeat (2) @(posedge clk); #1;
    start_req(0, 8'h5A, 3, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(psel_o && paddr_o == 8'h02) && n < 500);
    chk("s6_reach_tx", {psel_o, paddr_o}, {1'b1, 8'h02});
    #3;
    do_reset();
    apb_log.delete();
    drive_ports(0);
    wait_done(0, n);
    chk("s6_nops", apb_log.size(), 8);
    if (apb_log.size() > 0) chk("s6_first", apb_log[0], {1'b1, 8'h00, 8'h04});

    // random traffic from both requesters
    fork
      rand_txns(0);
      rand_txns(1);
    join
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
